// File: rtl/bg_scroll_ctrl.sv
// Per-frame background scheduler: one shared add/subtract/wrap datapath updates horizon and three clouds, then commits all four at once.
// Tick to new outputs is 6 cycles; frame_tick while busy is dropped and flags overrun.
module bg_scroll_ctrl #(
    parameter logic [9:0] CLOUD1_X0 = 10'd10,
    parameter logic [9:0] CLOUD2_X0 = 10'd100,
    parameter logic [9:0] CLOUD3_X0 = 10'd500,
    parameter logic [9:0] WRAP_X    = 10'd640,
    parameter logic [9:0] SCREEN_W  = 10'd640,
    parameter int         CLOUD_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       run,
    input  logic [3:0] speed,
    input  logic       restart,
    output logic [9:0] cloud1_x,
    output logic [9:0] cloud2_x,
    output logic [9:0] cloud3_x,
    output logic [9:0] horizon_off,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    typedef enum logic [2:0] {IDLE, CALC_H, CALC_C1, CALC_C2, CALC_C3, COMMIT} state_t;

    localparam logic [3:0] DIV_LAST = 4'(CLOUD_DIV - 1);

    state_t      r_state, w_next;
    logic        w_accept, w_commit, w_calc_h;
    logic [3:0]  w_step;
    logic [3:0]  r_step, r_cstep, r_div;
    logic        r_pend, r_ovr, r_done;
    logic [9:0]  r_c1, r_c2, r_c3, r_hor;
    logic [9:0]  r_sh_c1, r_sh_c2, r_sh_c3, r_sh_h;
    logic [10:0] w_opa, w_sub, w_res11;
    logic [9:0]  w_res;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (frame_tick) w_next = CALC_H;
            CALC_H:  w_next = CALC_C1;
            CALC_C1: w_next = CALC_C2;
            CALC_C2: w_next = CALC_C3;
            CALC_C3: w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != IDLE);
        w_accept = frame_tick && (r_state == IDLE);
        w_commit = (r_state == COMMIT);
        w_calc_h = (r_state == CALC_H);
    end

    assign w_step = run ? speed : 4'd0;

    // Horizon adds step and wraps by SCREEN_W; clouds subtract cloud_step and wrap by WRAP_X.
    always_comb begin
        w_opa = 11'd0;
        case (r_state)
            CALC_H:  w_opa = {1'b0, r_hor} + {7'd0, r_step};
            CALC_C1: w_opa = {1'b0, r_c1};
            CALC_C2: w_opa = {1'b0, r_c2};
            CALC_C3: w_opa = {1'b0, r_c3};
            default: w_opa = 11'd0;
        endcase
        w_sub = w_calc_h ? {1'b0, SCREEN_W} : {7'd0, r_cstep};
        if (w_opa >= w_sub)
            w_res11 = w_opa - w_sub;
        else if (w_calc_h)
            w_res11 = w_opa;
        else
            w_res11 = w_opa + {1'b0, WRAP_X} - w_sub;
        w_res = w_res11[9:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step  <= 4'd0;
            r_cstep <= 4'd0;
            r_div   <= 4'd0;
            r_pend  <= 1'b0;
            r_ovr   <= 1'b0;
            r_done  <= 1'b0;
            r_sh_h  <= 10'd0;
            r_sh_c1 <= 10'd0;
            r_sh_c2 <= 10'd0;
            r_sh_c3 <= 10'd0;
            r_hor   <= 10'd0;
            r_c1    <= CLOUD1_X0;
            r_c2    <= CLOUD2_X0;
            r_c3    <= CLOUD3_X0;
        end else begin
            r_done <= w_commit;
            if (w_accept) begin
                r_step  <= w_step;
                r_cstep <= (r_div == DIV_LAST) ? w_step : 4'd0;
                r_div   <= (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
            end
            case (r_state)
                CALC_H:  r_sh_h  <= w_res;
                CALC_C1: r_sh_c1 <= w_res;
                CALC_C2: r_sh_c2 <= w_res;
                CALC_C3: r_sh_c3 <= w_res;
                default: ;
            endcase
            if (frame_tick && busy) r_ovr <= 1'b1;
            if (restart)            r_pend <= 1'b1;
            // A restart arriving in the COMMIT cycle itself still applies here.
            if (w_commit) begin
                if (r_pend || restart) begin
                    r_hor  <= 10'd0;
                    r_c1   <= CLOUD1_X0;
                    r_c2   <= CLOUD2_X0;
                    r_c3   <= CLOUD3_X0;
                    r_div  <= 4'd0;
                    r_ovr  <= 1'b0;
                    r_pend <= 1'b0;
                end else begin
                    r_hor <= r_sh_h;
                    r_c1  <= r_sh_c1;
                    r_c2  <= r_sh_c2;
                    r_c3  <= r_sh_c3;
                end
            end
        end
    end

    assign cloud1_x    = r_c1;
    assign cloud2_x    = r_c2;
    assign cloud3_x    = r_c3;
    assign horizon_off = r_hor;
    assign done        = r_done;
    assign overrun     = r_ovr;

endmodule
